// File: rtl/pulse_sched_if.sv
// Request/response bundle between the two pulse requesters and pulse_sched.
// The master side drives the requests; the slave side is the scheduler.
interface pulse_sched_if #(
  parameter int CW = 4,
  parameter int PW = 4
);
  logic          req0;
  logic [CW-1:0] cnt0;
  logic [PW-1:0] half0;
  logic          req1;
  logic [CW-1:0] cnt1;
  logic [PW-1:0] half1;
  logic          signal;
  logic          busy;
  logic [1:0]    gnt;
  logic [1:0]    done;

  modport master (
    output req0, cnt0, half0, req1, cnt1, half1,
    input  signal, busy, gnt, done
  );

  modport slave (
    input  req0, cnt0, half0, req1, cnt1, half1,
    output signal, busy, gnt, done
  );
endinterface

// File: rtl/pulse_sched.sv
// Round-robin burst scheduler driving a shared square-pulse line.
// Optional abort input is enabled by defining PULSE_SCHED_ABORT_EN.
module pulse_sched #(
  parameter int CW = 4,
  parameter int PW = 4
) (
  input  logic          clock,
  input  logic          reset,
`ifdef PULSE_SCHED_ABORT_EN
  input  logic          abort,
`endif
  pulse_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [PW-1:0] half_q, half_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          owner_q, owner_d;
  logic          rr_q, rr_d;
  logic          signal_q, signal_d;
  logic          busy_q, busy_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    done_q, done_d;

  logic          pick;
  logic [CW-1:0] sel_cnt;
  logic [PW-1:0] sel_half;
  logic [PW-1:0] sel_h;
  logic [CW-1:0] rem_dec;
  logic [1:0]    owner_mask;
  logic          abort_hit;

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    half_d     = half_q;
    rem_d      = rem_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    signal_d   = signal_q;
    busy_d     = busy_q;
    gnt_d      = gnt_q;
    done_d     = 2'b00;

    pick       = (bus.req0 && bus.req1) ? rr_q : bus.req1;
    sel_cnt    = pick ? bus.cnt1 : bus.cnt0;
    sel_half   = pick ? bus.half1 : bus.half0;
    sel_h      = (sel_half == '0) ? PW'(1) : sel_half;
    rem_dec    = rem_q - CW'(1);
    owner_mask = {owner_q, ~owner_q};
`ifdef PULSE_SCHED_ABORT_EN
    abort_hit  = abort;
`else
    abort_hit  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          owner_d = pick;
          gnt_d   = pick ? 2'b10 : 2'b01;
          half_d  = sel_h;
          rem_d   = sel_cnt;
          phase_d = sel_h - PW'(1);
          if (sel_cnt != '0) begin
            state_d  = HIGH;
            signal_d = 1'b1;
            busy_d   = 1'b1;
          end else begin
            state_d  = DONE;
            done_d   = pick ? 2'b10 : 2'b01;
          end
        end
      end
      HIGH: begin
        if (abort_hit) begin
          state_d  = DONE;
          signal_d = 1'b0;
          busy_d   = 1'b0;
          done_d   = owner_mask;
        end else if (phase_q == '0) begin
          state_d  = LOW;
          signal_d = 1'b0;
          phase_d  = half_q - PW'(1);
        end else begin
          phase_d  = phase_q - PW'(1);
        end
      end
      LOW: begin
        if (abort_hit) begin
          state_d  = DONE;
          signal_d = 1'b0;
          busy_d   = 1'b0;
          done_d   = owner_mask;
        end else if (phase_q == '0) begin
          // The remaining count only drops at the end of a full high/low period.
          rem_d = rem_dec;
          if (rem_dec == '0) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = owner_mask;
          end else begin
            state_d  = HIGH;
            signal_d = 1'b1;
            phase_d  = half_q - PW'(1);
          end
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        rr_d    = ~owner_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      half_q   <= '0;
      rem_q    <= '0;
      owner_q  <= 1'b0;
      rr_q     <= 1'b0;
      signal_q <= 1'b0;
      busy_q   <= 1'b0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      half_q   <= half_d;
      rem_q    <= rem_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      signal_q <= signal_d;
      busy_q   <= busy_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
    end
  end

  assign bus.signal = signal_q;
  assign bus.busy   = busy_q;
  assign bus.gnt    = gnt_q;
  assign bus.done   = done_q;

endmodule

// File: doc/pulse_sched.md
Name: pulse_sched

Overview:
Burst scheduler for the pulse-generation resource. Two requesters share a single pulse output. A round-robin arbiter grants the output to one requester at a time. A sequencing FSM then drives a programmed number of square pulses with a programmed half-period, measured in clock cycles. The block sits between the clock module and any consumer of the shared `signal` line.

Parameters:
CW, 4, width of pulse-count inputs and remaining-pulse counter
PW, 4, width of half-period inputs and phase counter

Ports:
clock   input   1    system clock; all state updates on rising edge
reset   input   1    synchronous, active-high reset
req0    input   1    requester 0 burst request (level, held until done[0])
cnt0    input   CW   requester 0 number of pulses
half0   input   PW   requester 0 half-period in cycles
req1    input   1    requester 1 burst request
cnt1    input   CW   requester 1 number of pulses
half1   input   PW   requester 1 half-period in cycles
signal  output  1    shared pulse output (registered)
busy    output  1    high while a burst is in HIGH/LOW phases
gnt     output  2    one-hot current owner (bit0=req0, bit1=req1)
done    output  2    one-cycle completion strobe to owner

Behaviour:
- All outputs are registered.
- Reset (sampled at an edge, including mid-burst) sets: signal=0, busy=0, gnt=00, done=00, state=IDLE, rr pointer=0 (req0 preferred next).
- States: IDLE, HIGH, LOW, DONE.
- IDLE:
  - No req: stay in IDLE, all outputs 0.
  - One req: grant that requester.
  - Both reqs: grant the requester selected by the rr pointer.
  - On the grant edge:
    - latch cnt and half of the winner;
    - H = half, or 1 if half==0;
    - gnt=owner.
    - If latched cnt != 0: state=HIGH, signal=1, busy=1, phase counter=H-1, remaining=cnt.
    - If latched cnt == 0: state=DONE directly; no pulse is emitted.
- HIGH:
  - signal=1 for exactly H cycles.
  - When the phase counter reaches 0: state=LOW, signal=0, phase counter reloads to H-1.
- LOW:
  - signal=0 for exactly H cycles.
  - At the end of the phase, remaining is decremented.
  - If the new remaining is 0: state=DONE. Otherwise: state=HIGH, signal=1, phase counter reloads.
- DONE (exactly one cycle):
  - done[owner]=1, gnt still = owner, busy=0, signal=0.
  - rr pointer is set to the non-owner.
  - Next edge: state=IDLE, gnt=00, done=00.
- Burst timing: busy is high for 2*H*cnt cycles. signal shows cnt repetitions of H ones followed by H zeros.
- Inter-burst gap: 1 DONE cycle + 1 IDLE cycle before the next grant edge.
- Latched cnt and half are immune to input changes during a burst.
- Deasserting req mid-burst does not abort the burst; it runs to completion.
- Counters:
  - Phase counter is PW bits, counts down, no wrap (it is reloaded at 0).
  - Remaining counter is CW bits and never underflows (DONE is entered at 0).
- gnt is never 11. done is never 11.

Optional Feature:
Macro PULSE_SCHED_ABORT_EN.
- Defined:
  - Adds input port `abort` (1 bit).
  - `abort`=1 sampled in HIGH or LOW: next edge goes to DONE, signal=0, done[owner]=1, rr pointer advances as normal.
  - `abort` is ignored in IDLE and DONE.
- Undefined:
  - The `abort` port is absent.
  - Bursts always complete.

Test Plan:
1. Reset 2 cycles, then req0=1, cnt0=3, half0=2 → after grant edge: gnt=01, busy=1 for 12 cycles, signal=1,1,0,0 ×3. Then one cycle with done=01, gnt=01, busy=0. Then gnt=00.
2. From reset: req0=req1=1 same cycle, cnt0=1/half0=1, cnt1=2/half1=1, both held → req0 served first (signal 1,0; done=01). Two cycles later req1 granted (signal 1,0,1,0; done=10). With both still held, the next grant goes to req0 (round-robin).
3. req1=1, cnt1=0, half1=5 → the cycle after the grant edge shows gnt=10, done=10, busy=0, signal=0. No pulse is emitted.
4. req0=1, cnt0=2, half0=0 → treated as H=1: signal=1,0,1,0, busy high for 4 cycles.
5. req0 burst with cnt0=4, half0=3; assert reset for one edge in the 5th HIGH cycle → the next cycle shows signal=0, busy=0, gnt=00, done=00. After reset is released, with req0 and req1 both still asserted, req0 is granted (rr pointer=0).
6. (PULSE_SCHED_ABORT_EN) req1 burst with cnt1=5, half1=2; abort=1 in the 3rd cycle → next cycle: state DONE, done=10, signal=0. The following IDLE arbitration prefers req0.
